// File: rtl/alu_n_pkg.sv
// alu_n_pkg
//   Shared definitions for pipelined_alu_n and its helpers:
//   - MODE_* : 4-bit opcode map (same as the 16-bit combinational ALU)
//   - ST_*   : control state encoding (IDLE / EXEC / DONE)
//   - is_shift() : true for the four iterative shift modes (0-3)
package alu_n_pkg;

   localparam logic [3:0] MODE_SLL    = 4'd0;
   localparam logic [3:0] MODE_ASL    = 4'd1;
   localparam logic [3:0] MODE_SRL    = 4'd2;
   localparam logic [3:0] MODE_SRA    = 4'd3;
   localparam logic [3:0] MODE_ADD    = 4'd4;
   localparam logic [3:0] MODE_SUB    = 4'd5;
   localparam logic [3:0] MODE_AND    = 4'd6;
   localparam logic [3:0] MODE_OR     = 4'd7;
   localparam logic [3:0] MODE_NOTA   = 4'd8;
   localparam logic [3:0] MODE_XOR    = 4'd9;
   localparam logic [3:0] MODE_XNOR   = 4'd10;
   localparam logic [3:0] MODE_NOR    = 4'd11;
   localparam logic [3:0] MODE_ONEHOT = 4'd12;
   localparam logic [3:0] MODE_LTU    = 4'd13;
   localparam logic [3:0] MODE_PASSB  = 4'd14;
   localparam logic [3:0] MODE_LEAD1  = 4'd15;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Modes 0-3 are the shifts; they share the top two opcode bits.
   function automatic logic is_shift(input logic [3:0] m);
      return (m[3:2] == 2'b00);
   endfunction

endpackage

// File: rtl/cla_adder_n.sv
// cla_adder_n
//   WIDTH-bit adder built as a ripple of 4-bit carry-lookahead groups.
//   Inside a group every carry is computed directly from generate /
//   propagate terms; only the group carry ripples to the next group.
//   WIDTH must be a multiple of 4.
// Ports:
//   a_i, b_i : addends
//   c_i      : carry into bit 0
//   s_o      : sum
//   c_o      : carry out of the MSB
module cla_adder_n #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o
);

   localparam int NG = WIDTH / 4;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;     // carry into each bit position
   logic [NG:0]      gc;    // carry into each 4-bit group

   assign g     = a_i & b_i;
   assign p     = a_i ^ b_i;
   assign gc[0] = c_i;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] gg;
      logic [3:0] pp;
      logic       c0;

      assign gg = g[4*k +: 4];
      assign pp = p[4*k +: 4];
      assign c0 = gc[k];

      assign c[4*k]   = c0;
      assign c[4*k+1] = gg[0] | (pp[0] & c0);
      assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & c0);
      assign gc[k+1]  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0])
                      | (&pp & c0);
   end

   assign s_o = p ^ c;
   assign c_o = gc[NG];

endmodule

// File: rtl/pipelined_alu_n.sv
// pipelined_alu_n
//   Sequential WIDTH-bit ALU with a 16-mode opcode map. Operand sets are
//   accepted through a valid/ready handshake; the result and flags are
//   registered and held until the consumer takes them. Shifts (modes 0-3)
//   move one bit position per clock; every other mode completes at the
//   accept edge.
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high. On the input side a/b/cin/mode are sampled only at that
//   edge; on the output side y/cout/overflow stay stable while out_valid is
//   high and out_ready is low, and a new operand set may be accepted in the
//   same cycle the old result is taken (no bubble).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake
//   a, b, cin, mode     : operands, carry-in (mode 4 only), opcode
//                         (b[SHW-1:0] is the shift amount for modes 0-3)
//   out_valid/out_ready : result handshake
//   y, cout, overflow   : registered result and flags
//   busy                : high while an iterative shift is running
module pipelined_alu_n
   import alu_n_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int               MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] work_q, work_d;    // operand being shifted
   logic [SHW-1:0]   cnt_q, cnt_d;      // shift steps still to do
   logic [1:0]       shop_q, shop_d;    // which shift (mode[1:0])
   logic             sovf_q, sovf_d;    // sticky sign change for ASL

   logic             accept;
   logic [SHW-1:0]   amt;

   assign amt       = b[SHW-1:0];
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_EXEC);
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign y         = y_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

   // ---------------------------------------------------------------
   // Shared adder: subtract is A + ~B + 1 through the same instance.
   // ---------------------------------------------------------------
   logic             is_sub;
   logic [WIDTH-1:0] add_b;
   logic             add_c;
   logic [WIDTH-1:0] add_s;
   logic             add_co;

   assign is_sub = (mode == MODE_SUB);
   assign add_b  = is_sub ? ~b : b;
   assign add_c  = is_sub ? 1'b1 : cin;

   cla_adder_n #(.WIDTH(WIDTH)) u_add (
      .a_i (a),
      .b_i (add_b),
      .c_i (add_c),
      .s_o (add_s),
      .c_o (add_co)
   );

   // ---------------------------------------------------------------
   // Leading-one position: last set bit scanning upward wins.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] lead1;

   always_comb begin
      lead1 = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (a[i]) lead1 = WIDTH'(i + 1);
      end
   end

   // ---------------------------------------------------------------
   // Single-cycle result. Shift modes land here only with amount 0,
   // where the result is simply A with no flags.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] res_y;
   logic             res_c;
   logic             res_o;

   always_comb begin
      res_y = '0;
      res_c = 1'b0;
      res_o = 1'b0;
      case (mode)
         MODE_SLL, MODE_ASL, MODE_SRL, MODE_SRA: res_y = a;
         MODE_ADD: begin
            res_y = add_s;
            res_c = add_co;
            res_o = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
         end
         MODE_SUB: begin
            res_y = add_s;
            res_c = add_co;
            res_o = (a[MSB] != b[MSB]) && (add_s[MSB] != a[MSB]);
         end
         MODE_AND:    res_y = a & b;
         MODE_OR:     res_y = a | b;
         MODE_NOTA:   res_y = ~a;
         MODE_XOR:    res_y = a ^ b;
         MODE_XNOR:   res_y = ~(a ^ b);
         MODE_NOR:    res_y = ~(a | b);
         MODE_ONEHOT: res_y = ONE << a[SHW-1:0];
         MODE_LTU:    res_y = (a < b) ? ONE : '0;
         MODE_PASSB:  res_y = b;
         MODE_LEAD1:  res_y = lead1;
         default:     res_y = '0;
      endcase
   end

   // ---------------------------------------------------------------
   // One shift step on the work register.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] step_w;
   logic             step_ovf;

   always_comb begin
      step_w = work_q;
      case (shop_q)
         MODE_SLL[1:0], MODE_ASL[1:0]: step_w = {work_q[MSB-1:0], 1'b0};
         MODE_SRL[1:0]:                step_w = {1'b0, work_q[MSB:1]};
         default:                      step_w = {work_q[MSB], work_q[MSB:1]};
      endcase
   end

   // A left shift changes the sign exactly when the two top bits differ.
   assign step_ovf = (shop_q == MODE_ASL[1:0]) && (work_q[MSB] != work_q[MSB-1]);

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      shop_d  = shop_q;
      sovf_d  = sovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
            if (accept) begin
               if (is_shift(mode) && (amt != '0)) begin
                  state_d = ST_EXEC;
                  work_d  = a;
                  cnt_d   = amt;
                  shop_d  = mode[1:0];
                  sovf_d  = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  y_d     = res_y;
                  cout_d  = res_c;
                  ovf_d   = res_o;
               end
            end
         end

         ST_EXEC: begin
            work_d = step_w;
            cnt_d  = cnt_q - 1'b1;
            sovf_d = sovf_q | step_ovf;
            if (cnt_q == SHW'(1)) begin
               state_d = ST_DONE;
               y_d     = step_w;
               cout_d  = 1'b0;
               ovf_d   = sovf_q | step_ovf;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         work_q  <= '0;
         cnt_q   <= '0;
         shop_q  <= '0;
         sovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         shop_q  <= shop_d;
         sovf_q  <= sovf_d;
      end
   end

endmodule

// File: tb/tb_pipelined_alu_n.sv
// Self-checking bench for pipelined_alu_n (WIDTH=16): directed cases with
// literal expectations, then randomized operand sets with random consumer
// backpressure, all results checked against a behavioural model.
module tb_pipelined_alu_n;

   localparam int W  = 16;
   localparam int RW = W + 2;   // {y, cout, overflow}

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic [3:0]   mode = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] y;
   logic         cout;
   logic         overflow;
   logic         busy;

   int           total = 0;
   int           bad = 0;
   logic [RW-1:0] exp_q[$];
   bit           rand_ready = 1'b0;

   pipelined_alu_n #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish before 400000");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic [3:0] mm);
      int           s;
      int           ua, ub, sa, sb, sum, ss, lim;
      logic [W-1:0] ry;
      logic         rc, ro;
      s  = int'(mb[3:0]);
      ua = int'(ma);
      ub = int'(mb);
      sa = $signed(ma);
      sb = $signed(mb);
      ry = '0;
      rc = 1'b0;
      ro = 1'b0;
      case (mm)
         4'd0: ry = ma << s;
         4'd1: begin
            ry  = ma << s;
            // sign changes at some step iff A as a signed value does not fit in W-s bits
            lim = 1 << (W - 1 - s);
            ro  = (sa < -lim) || (sa >= lim);
         end
         4'd2: ry = ma >> s;
         4'd3: ry = W'($signed(ma) >>> s);
         4'd4: begin
            sum = ua + ub + int'(mc);
            ry  = W'(sum);
            rc  = (sum >= (1 << W));
            ss  = sa + sb + int'(mc);
            ro  = (ss > 32767) || (ss < -32768);
         end
         4'd5: begin
            ry = W'(ua - ub);
            rc = (ua >= ub);
            ss = sa - sb;
            ro = (ss > 32767) || (ss < -32768);
         end
         4'd6:  ry = ma & mb;
         4'd7:  ry = ma | mb;
         4'd8:  ry = ~ma;
         4'd9:  ry = ma ^ mb;
         4'd10: ry = ~(ma ^ mb);
         4'd11: ry = ~(ma | mb);
         4'd12: ry[ma[3:0]] = 1'b1;
         4'd13: ry = (ua < ub) ? W'(1) : W'(0);
         4'd14: ry = mb;
         default: begin
            for (int i = 0; i < W; i++) if (ma[i]) ry = W'(i + 1);
         end
      endcase
      return {ry, rc, ro};
   endfunction

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result_without_op: got y=0x%0h, required no result", y);
         end else begin
            chk("sb_y", 32'(y), 32'(exp_q[0][RW-1:2]));
            chk("sb_cout", 32'(cout), 32'(exp_q[0][1]));
            chk("sb_ovf", 32'(overflow), 32'(exp_q[0][0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- random consumer ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   // Call at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [3:0] tm, output int waited);
      a = ta; b = tb_; cin = tc; mode = tm; in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      else exp_q.push_back(model(ta, tb_, tc, tm));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); mode = 4'($urandom);
   endtask

   task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [3:0] tm, input int exp_lat,
                        input logic [W-1:0] ey, input logic ec, input logic eo);
      int w, n, nb;
      send(ta, tb_, tc, tm, w);
      n = 0;
      nb = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy) begin
            nb++;
            chk({name, "_in_ready_exec"}, 32'(in_ready), 32'd0);
         end
      end while (!out_valid && n < 40);
      chk({name, "_lat"}, 32'(n), 32'(exp_lat));
      chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
      chk({name, "_y"}, 32'(y), 32'(ey));
      chk({name, "_cout"}, 32'(cout), 32'(ec));
      chk({name, "_ovf"}, 32'(overflow), 32'(eo));
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int           w, n, k;
      logic [W-1:0] ra, rb;
      logic [3:0]   rm;

      // pin the model with hand-computed values
      chk("pin_add", 32'(model(16'h7FFF, 16'h0001, 1'b0, 4'd4)), 32'({16'h8000, 1'b0, 1'b1}));
      chk("pin_sub", 32'(model(16'h8000, 16'h0001, 1'b0, 4'd5)), 32'({16'h7FFF, 1'b1, 1'b1}));
      chk("pin_sra", 32'(model(16'h8010, 16'h0004, 1'b0, 4'd3)), 32'({16'hF801, 2'b00}));
      chk("pin_lead1", 32'(model(16'h0100, 16'h0000, 1'b0, 4'd15)), 32'({16'h0009, 2'b00}));
      chk("pin_asl", 32'(model(16'h4000, 16'h0001, 1'b0, 4'd1)), 32'({16'h8000, 2'b01}));

      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // directed cases (consumer always ready)
      out_ready = 1'b1;
      do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 4'd4, 1, 16'h8000, 1'b0, 1'b1);
      do_op("add_cin", 16'hFFFF, 16'h0000, 1'b1, 4'd4, 1, 16'h0000, 1'b1, 1'b0);
      do_op("sub_neg", 16'h0003, 16'h0005, 1'b1, 4'd5, 1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 4'd5, 1, 16'h7FFF, 1'b1, 1'b1);
      do_op("sra4", 16'h8010, 16'h0004, 1'b0, 4'd3, 5, 16'hF801, 1'b0, 1'b0);
      do_op("srl15", 16'hFFFF, 16'h000F, 1'b0, 4'd2, 16, 16'h0001, 1'b0, 1'b0);
      do_op("sll_amt0", 16'h1234, 16'h0010, 1'b0, 4'd0, 1, 16'h1234, 1'b0, 1'b0);
      do_op("asl_ovf", 16'h4000, 16'h0001, 1'b0, 4'd1, 2, 16'h8000, 1'b0, 1'b1);
      do_op("onehot", 16'h0005, 16'h0000, 1'b0, 4'd12, 1, 16'h0020, 1'b0, 1'b0);
      do_op("lead1", 16'h0100, 16'h0000, 1'b0, 4'd15, 1, 16'h0009, 1'b0, 1'b0);
      do_op("lead1_zero", 16'h0000, 16'hFFFF, 1'b0, 4'd15, 1, 16'h0000, 1'b0, 1'b0);
      do_op("ltu", 16'h0002, 16'h0003, 1'b0, 4'd13, 1, 16'h0001, 1'b0, 1'b0);

      // backpressure then back-to-back accept
      out_ready = 1'b0;
      send(16'h00FF, 16'h0F0F, 1'b0, 4'd9, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_y_hold", 32'(y), 32'h0FF0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'h0000, 16'h1234, 1'b0, 4'd14, w);
      chk("bp_no_bubble", 32'(w), 32'd0);
      @(negedge clk);
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_y", 32'(y), 32'h1234);
      @(posedge clk);
      #1;

      // reset in the middle of a 10-step shift
      send(16'h0001, 16'h000A, 1'b0, 4'd0, w);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_y", 32'(y), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // randomized operations with random backpressure
      rand_ready = 1'b1;
      repeat (300) begin
         rm = 4'($urandom_range(0, 15));
         k  = $urandom_range(0, 4);
         ra = (k == 0) ? 16'h0000 : (k == 1) ? 16'hFFFF : (k == 2) ? 16'h8000 :
              (k == 3) ? 16'h7FFF : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
         send(ra, rb, 1'($urandom), rm, w);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_alu_n.md
Name: pipelined_alu_n

Overview:
- Parametrised, sequential successor to the team's 16-bit combinational ALU. Same 16-mode opcode map, generalised to WIDTH bits.
- Operands enter through a valid/ready handshake. Results and flags are registered and held until the consumer accepts them.
- Shift modes take a variable amount from B and execute iteratively, one bit position per cycle.
- Sits between the lab register file and the result bus; in_valid is driven by the controller FSM.

Parameters:
- WIDTH, 16, datapath width; must be a multiple of 4 and at least 8.
- SHW, $clog2(WIDTH), derived; width of the shift amount and one-hot index.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept an operand set this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount in modes 0-3
- cin  input  1  carry-in, used by mode 4 only
- mode  input  4  opcode
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer accepts the result
- y  output  WIDTH  registered result
- cout  output  1  registered carry-out
- overflow  output  1  registered signed overflow
- busy  output  1  high in EXEC state

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; y, cout, overflow, out_valid and busy are 0; in_ready=1 in the cycle after reset.
- States:
  - IDLE: no result held.
  - EXEC: iterative shift in progress.
  - DONE: result held.
- Handshake:
  - Accept occurs on a clock edge with in_valid and in_ready both high. a, b, cin and mode are sampled only at accept.
  - in_ready = (state==IDLE) or (state==DONE and out_ready). Back-to-back operations with no bubble are allowed.
  - y, cout and overflow are stable while out_valid=1 and out_ready=0.
  - DONE with out_ready=1 and no accept: go to IDLE, out_valid falls.
- Accepting a non-shift mode, or a shift with amount 0: result is registered at the accept edge and state goes to DONE. Latency is 1 cycle.
- Accepting a shift with amount s>0:
  - Go to EXEC; work=a, count=s.
  - Each EXEC edge shifts work by 1 and decrements count. The edge where count reaches 0 loads y and goes to DONE.
  - Latency is s+1 cycles. in_valid is ignored during EXEC.
- Modes (A=a, B=b):
  - 0: logical shift left.
  - 1: arithmetic shift left. overflow=1 if the sign bit changes at any step.
  - 2: logical shift right.
  - 3: arithmetic shift right; the MSB is replicated.
  - 4: add. {cout,y}=A+B+cin. overflow=(A[msb]==B[msb]) and (y[msb]!=A[msb]).
  - 5: subtract. y=A+~B+1; cin is ignored. cout=1 means no borrow. overflow=(A[msb]!=B[msb]) and (y[msb]!=A[msb]).
  - 6: A&B.
  - 7: A|B.
  - 8: ~A.
  - 9: A^B.
  - 10: ~(A^B).
  - 11: ~(A|B).
  - 12: one-hot; y=1<<A[SHW-1:0].
  - 13: unsigned compare; y=1 if A<B, else 0.
  - 14: y=B.
  - 15: leading one; y=(index of the highest set bit of A)+1, and y=0 when A=0.
- Flag scope:
  - cout=0 in every mode except 4 and 5.
  - overflow=0 in every mode except 1, 4 and 5.
  - Every mode writes every flag, so no flag value carries over from a previous operation.
- Reset mid-EXEC or mid-DONE aborts the operation. The held result is discarded and all outputs return to reset values on the next edge.
- A shift amount of WIDTH-1 is legal: latency is WIDTH cycles.

Decomposition:
- Package alu_n_pkg holds:
  - mode localparams: MODE_SLL=0 through MODE_LEAD1=15;
  - state encoding: ST_IDLE, ST_EXEC, ST_DONE.
- One sub-module, cla_adder_n (parameter WIDTH): a ripple of 4-bit carry-lookahead groups. One instance is used for add and for subtract, with operand B muxed to B or ~B and carry-in muxed to cin or 1.

Test Plan (WIDTH=16):
- Add overflow: mode 4, a=0x7FFF, b=0x0001, cin=0, accept at cycle t. Required: out_valid at t+1, y=0x8000, overflow=1, cout=0.
- Subtract:
  - mode 5, a=0x0003, b=0x0005: y=0xFFFE, cout=0, overflow=0.
  - then a=0x8000, b=0x0001: y=0x7FFF, cout=1, overflow=1.
- Arithmetic shift right: mode 3, a=0x8010, b=4. Required: busy high for 4 cycles, out_valid at accept+5, y=0xF801, in_ready=0 during EXEC.
- Backpressure: mode 9 result with out_ready=0 for 3 cycles. Required: y held stable and in_ready=0. Then out_ready=1 with in_valid=1 and mode 14, b=0x1234: new op accepted with no bubble, next y=0x1234.
- Reset mid-operation: mode 0, b=10, assert rst at cycle 4 of EXEC. Required: next cycle out_valid=0, busy=0, y=0, in_ready=1.
- Misc modes:
  - mode 12, a=0x0005: y=0x0020.
  - mode 15, a=0x0100: y=9; a=0: y=0.
  - mode 13, a=2, b=3: y=1.
  - mode 1, a=0x4000, b=1: y=0x8000, overflow=1.
